// File: rtl/switch_conditioner.sv
// Four-channel switch debouncer with rising-edge pulses and a single-entry press event register.
// Optional two-flop input synchronizer enabled by defining SWCOND_SYNC_EN.
module switch_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] SWITCHES,
    output logic [3:0] sw_level,
    output logic [3:0] sw_rise,
    output logic       press_valid,
    output logic [1:0] press_code,
    input  logic       press_ready,
    output logic       drop_flag,
    input  logic       drop_clr
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       s;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       level_q, level_d;
    logic [3:0]       rise_q, rise_d;
    logic             valid_q, valid_d;
    logic [1:0]       code_q, code_d;
    logic             drop_q, drop_d;

    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

`ifdef SWCOND_SYNC_EN
    logic [3:0] sync1_q, sync2_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= SWITCHES;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = SWITCHES;
`endif

    // Any sample that agrees with the accepted level discards the count entirely.
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (s[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = s[i];
                    rise_d[i]  = s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic load, multi, drop_set;

    always_comb begin
        load     = (|rise_q) && (!valid_q || press_ready);
        multi    = (rise_q & (rise_q - 4'd1)) != 4'd0;
        drop_set = ((|rise_q) && valid_q && !press_ready) || multi;

        valid_d = valid_q;
        code_d  = code_q;
        if (load) begin
            valid_d = 1'b1;
            code_d  = lowest_idx(rise_q);
        end else if (valid_q && press_ready) begin
            valid_d = 1'b0;
        end

        drop_d = drop_q;
        if (drop_set)      drop_d = 1'b1;
        else if (drop_clr) drop_d = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            level_q <= '0;
            rise_q  <= '0;
            valid_q <= 1'b0;
            code_q  <= 2'd0;
            drop_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            level_q <= level_d;
            rise_q  <= rise_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            drop_q  <= drop_d;
        end
    end

    assign sw_level    = level_q;
    assign sw_rise     = rise_q;
    assign press_valid = valid_q;
    assign press_code  = code_q;
    assign drop_flag   = drop_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner at DEBOUNCE_CYCLES=4 with the input synchronizer disabled.
module tb_switch_conditioner;

    logic       clock;
    logic       reset;
    logic [3:0] SWITCHES;
    logic [3:0] sw_level;
    logic [3:0] sw_rise;
    logic       press_valid;
    logic [1:0] press_code;
    logic       press_ready;
    logic       drop_flag;
    logic       drop_clr;

    int n_cmp  = 0;
    int n_fail = 0;

    switch_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .SWITCHES    (SWITCHES),
        .sw_level    (sw_level),
        .sw_rise     (sw_rise),
        .press_valid (press_valid),
        .press_code  (press_code),
        .press_ready (press_ready),
        .drop_flag   (drop_flag),
        .drop_clr    (drop_clr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {sw_level, sw_rise}, 8'h00);
        check(tag, {4'd0, press_valid, press_code, drop_flag}, 8'h00);
    endtask

    logic seen;

    initial begin
        reset       = 1'b0;
        SWITCHES    = 4'b0000;
        press_ready = 1'b1;
        drop_clr    = 1'b0;
        tick(2);
        check_all_zero("reset_state");
        reset = 1'b1;
        tick(2);
        check_all_zero("idle_after_reset");

        // Clean press on switch 1
        SWITCHES = 4'b0010;
        tick(3);
        check("a_level_before", {4'd0, sw_level}, 8'h00);
        tick(1);
        check("a_level", {4'd0, sw_level}, 8'h02);
        check("a_rise", {4'd0, sw_rise}, 8'h02);
        check("a_valid_early", {7'd0, press_valid}, 8'h00);
        tick(1);
        check("a_rise_gone", {4'd0, sw_rise}, 8'h00);
        check("a_valid", {7'd0, press_valid}, 8'h01);
        check("a_code", {6'd0, press_code}, 8'h01);
        tick(1);
        check("a_valid_clear", {7'd0, press_valid}, 8'h00);
        SWITCHES = 4'b0000;
        tick(3);
        check("a_fall_level_hold", {4'd0, sw_level}, 8'h02);
        tick(1);
        check("a_fall_level", {4'd0, sw_level}, 8'h00);
        check("a_fall_no_rise", {4'd0, sw_rise}, 8'h00);
        tick(2);

        // Bouncing switch 0 never accepted
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            SWITCHES = {3'b000, (i % 2 == 0)};
            tick(1);
            seen = seen | (|sw_level) | (|sw_rise) | press_valid;
        end
        check("b_bounce_quiet", {7'd0, seen}, 8'h00);
        SWITCHES = 4'b0000;
        tick(2);

        // A one-cycle glitch restarts the count
        SWITCHES = 4'b0001;
        tick(3);
        SWITCHES = 4'b0000;
        tick(1);
        SWITCHES = 4'b0001;
        tick(3);
        check("b_restart_hold", {4'd0, sw_level}, 8'h00);
        tick(1);
        check("b_restart_level", {4'd0, sw_level, sw_rise}, 8'h11);
        tick(1);
        check("b_restart_press", {5'd0, press_valid, press_code}, 8'h04);
        SWITCHES = 4'b0000;
        tick(6);

        // Simultaneous rise on switches 2 and 3
        SWITCHES = 4'b1100;
        tick(4);
        check("c_rise", {4'd0, sw_rise}, 8'h0C);
        tick(1);
        check("c_press", {5'd0, press_valid, press_code}, 8'h06);
        check("c_drop", {7'd0, drop_flag}, 8'h01);
        drop_clr = 1'b1;
        tick(1);
        drop_clr = 1'b0;
        check("c_drop_clr", {7'd0, drop_flag}, 8'h00);
        check("c_valid_clear", {7'd0, press_valid}, 8'h00);
        SWITCHES = 4'b0000;
        tick(6);

        // Stalled consumer: switch 3 then switch 0
        press_ready = 1'b0;
        SWITCHES = 4'b1000;
        tick(5);
        check("d_press3", {5'd0, press_valid, press_code}, 8'h07);
        SWITCHES = 4'b1001;
        tick(4);
        check("d_rise0", {4'd0, sw_rise}, 8'h01);
        drop_clr = 1'b1;
        tick(1);
        drop_clr = 1'b0;
        check("d_drop_set_wins", {7'd0, drop_flag}, 8'h01);
        check("d_code_held", {5'd0, press_valid, press_code}, 8'h07);
        press_ready = 1'b1;
        tick(1);
        check("d_valid_clear", {7'd0, press_valid}, 8'h00);
        check("d_drop_sticky", {7'd0, drop_flag}, 8'h01);
        SWITCHES = 4'b0000;
        tick(6);

        // Reset mid-debounce with an event pending
        press_ready = 1'b0;
        SWITCHES = 4'b0001;
        tick(5);
        check("e_pending", {5'd0, press_valid, press_code}, 8'h04);
        SWITCHES = 4'b0101;
        tick(2);
        reset = 1'b0;
        SWITCHES = 4'b0100;
        #1;
        check_all_zero("e_async_reset");
        tick(1);
        check_all_zero("e_reset_held");
        reset = 1'b1;
        press_ready = 1'b1;
        tick(3);
        check("e_level_before", {4'd0, sw_level}, 8'h00);
        tick(1);
        check("e_level", {4'd0, sw_level, sw_rise}, 8'h44);
        tick(1);
        check("e_press2", {5'd0, press_valid, press_code}, 8'h06);
        check("e_no_drop", {7'd0, drop_flag}, 8'h00);
        tick(1);
        check("e_valid_clear", {7'd0, press_valid}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_conditioner.md
SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive clock cycles a changed switch value must persist before it is accepted (1..2^32-1); hardware builds use 1250000.
REQ-002 Port clock  input  1  single clock; all state is updated on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-004 Port SWITCHES  input  4  raw, asynchronous, bouncing player switches.
REQ-005 Port sw_level  output  4  debounced switch levels.
REQ-006 Port sw_rise  output  4  one-cycle pulse per channel, asserted in the same cycle its sw_level bit goes 0->1.
REQ-007 Port press_valid  output  1  a press event is pending.
REQ-008 Port press_code  output  2  index (0..3) of the pending pressed switch.
REQ-009 Port press_ready  input  1  consumer accepts the pending event.
REQ-010 Port drop_flag  output  1  sticky; at least one press event was lost.
REQ-011 Port drop_clr  input  1  synchronous clear of drop_flag.

Function
REQ-012 Each of the 4 channels SHALL be independent and identical: the input stage (see Configuration) produces s[i]; a counter per channel tracks persistence of s[i] != sw_level[i].
REQ-013 When s[i] == sw_level[i], the channel counter SHALL be 0 on the next edge.
REQ-014 When s[i] != sw_level[i] and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-015 When s[i] != sw_level[i] and counter == DEBOUNCE_CYCLES-1, sw_level[i] SHALL take s[i] and the counter SHALL return to 0 on that edge.
REQ-016 A bounce (s[i] returning to sw_level[i] before acceptance) SHALL restart the count from 0; no partial credit is retained.
REQ-017 Latency: a clean step first visible on s[i] at edge t SHALL appear on sw_level[i] at edge t+DEBOUNCE_CYCLES-1.
REQ-018 sw_rise[i] SHALL be 1 for exactly the one cycle following the edge where sw_level[i] goes 0->1; falling transitions produce no pulse.
REQ-019 Press register load condition: any sw_rise bit = 1 AND (press_valid == 0 OR press_ready == 1).
REQ-020 On load, press_valid SHALL be 1 and press_code SHALL be the lowest index i with sw_rise[i] = 1, both on the next edge.
REQ-021 If press_valid == 1, press_ready == 1 and no sw_rise bit is set, press_valid SHALL clear on the next edge.
REQ-022 press_code SHALL remain stable while press_valid == 1 and press_ready == 0.
REQ-023 drop_flag SHALL set on the next edge when a sw_rise bit is set while press_valid == 1 and press_ready == 0 (pending event kept), or when two or more sw_rise bits are set simultaneously (only lowest index captured).
REQ-024 drop_clr SHALL clear drop_flag on the next edge; if a drop condition occurs in the same cycle, set wins.
REQ-025 press_ready while press_valid == 0 SHALL have no effect.

Reset
REQ-026 While reset == 0, all counters, synchronizer flops, sw_level, sw_rise, press_valid, press_code and drop_flag SHALL be 0 immediately, independent of clock.
REQ-027 After reset deasserts, a switch already held high SHALL be treated as a new 0->1 transition and produce one press event after normal debounce latency.
REQ-028 Reset mid-debounce SHALL discard the partial count; no event is generated for the aborted transition.

Configuration
REQ-029 Macro SWCOND_SYNC_EN defined: s[i] is SWITCHES[i] passed through two reset-to-0 flops, adding 2 cycles to every latency in REQ-017.
REQ-030 Macro SWCOND_SYNC_EN undefined: s[i] = SWITCHES[i] directly (inputs already synchronous, e.g. in simulation); no other behaviour changes.

Verification (DEBOUNCE_CYCLES=4, SWCOND_SYNC_EN undefined)
REQ-031 SWITCHES 0000->0010 held, press_ready=1 -> sw_level[1]=1 and sw_rise=0010 pulse 3 edges after step; press_valid=1, press_code=1 for one cycle.
REQ-032 SWITCHES[0] toggles 1,0,1,0 with a 2-cycle period for 20 cycles -> sw_level stays 0000, no sw_rise, press_valid stays 0.
REQ-033 SWITCHES 0000->1100 in one cycle -> sw_rise=1100 pulse, press_code=2, drop_flag=1; drop_clr=1 for one cycle -> drop_flag=0.
REQ-034 press_ready=0; press switch 3 then switch 0 -> press_code stays 3, drop_flag=1; press_ready=1 -> press_valid clears next edge.
REQ-035 Assert reset=0 two cycles into a debounce of SWITCHES[2] while press_valid=1 -> all outputs 0 immediately; release with SWITCHES[2] still 1 -> one press_code=2 event after debounce.
REQ-036 Rebuild with SWCOND_SYNC_EN defined, repeat REQ-031 -> identical response shifted 2 cycles later.
